cvmcu_io_pad_cfg_ctrl: RTL and testbench
========================================

# cvmcu_io_pad_cfg_ctrl

Sequences glitch-safe reconfiguration of the CORE-V MCU IO pad mux. It accepts one pad-update request at a time: function select plus electrical config. For each update it gates the pad's output enable, waits a settle interval, switches the mux and config registers, and waits again before releasing the gate. It sits between the APB pad-control registers and the pad frame, and is the sole writer of pad mux and config state.

## Interface
- N_PADS, 48: number of managed pads.
- SEL_W, 2: function-select width per pad (4 functions).
- CFG_W, 6: electrical config width per pad (pull-up, pull-down, drive strength, slew).
- CFG_RST, 6'b000000: reset value of every pad's config.
- SETTLE_CYCLES, 4: cycles of gating before and after the switch. Must be at least 1.
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  1  update request valid.
- req_ready_o  out  1  controller can accept a request.
- req_pad_i  in  $clog2(N_PADS)  target pad index.
- req_sel_i  in  SEL_W  new function select.
- req_cfg_i  in  CFG_W  new electrical config.
- pad_sel_o  out  N_PADS*SEL_W  per-pad function select; pad p occupies bits [p*SEL_W +: SEL_W].
- pad_cfg_o  out  N_PADS*CFG_W  per-pad config; same packing as pad_sel_o.
- pad_oe_gate_o  out  N_PADS  1 = force pad output enable off.
- busy_o  out  1  update in progress (high whenever the state is not IDLE).
- done_o  out  1  one-cycle pulse when a request completes.
- err_o  out  1  one-cycle pulse, coincident with done_o, when the request was rejected.

## Operation
- States: IDLE, GATE, SWITCH, HOLD, DONE.
- Handshake:
  - A request is accepted on any clk_i edge where req_valid_i and req_ready_o are both high.
  - req_ready_o is high only in IDLE.
  - Request fields are captured at acceptance; later changes on the request inputs are ignored.
- IDLE -> GATE on acceptance when the pad index is valid and (sel, cfg) differs from the pad's current values.
- IDLE -> DONE, err_o=1, when req_pad_i >= N_PADS. No state changes.
- IDLE -> DONE, err_o=0, when the index is valid but sel and cfg are both unchanged. No gating occurs.
- GATE:
  - pad_oe_gate_o[p]=1.
  - The settle counter loads SETTLE_CYCLES-1 on entry and counts down.
  - Go to SWITCH when the counter reaches 0.
- SWITCH: one cycle with gate still high. pad_sel/pad_cfg for pad p are written at the end of this cycle.
- HOLD: gate high. The counter is reloaded; go to DONE when it reaches 0.
- DONE:
  - Gate low, done_o=1, err_o as determined at acceptance.
  - Next state is IDLE.
- Only the addressed pad's gate, sel and cfg are ever modified. All other pads hold their values.
- Reset values: pad_sel_o all 0, pad_cfg_o all CFG_RST, pad_oe_gate_o all 0, req_ready_o=1, busy_o=0, done_o=0, err_o=0, state IDLE.
- Reset mid-operation:
  - Any in-flight request is abandoned with no done_o.
  - All outputs take their reset values on the cycle after rst_i is sampled high, including the pad's gate and any partially applied update.

## Timing
- All outputs are registered.
- Take T as the acceptance edge:
  - T+1 .. T+S: GATE, with S = SETTLE_CYCLES.
  - T+S+1: SWITCH.
  - New pad_sel/pad_cfg are visible from T+S+2.
  - T+S+2 .. T+2S+1: HOLD.
  - T+2S+2: DONE, with gate low and done_o high.
  - T+2S+3: IDLE, with req_ready_o high.
- Full update latency from acceptance to done_o is 2S+2 cycles. For S=4, that is 10 cycles.
- The minimum back-to-back acceptance interval is 2S+3 cycles.
- Rejected and no-change requests: done_o at T+1; next acceptance possible at T+2.
- pad_oe_gate_o[p] rises at T+1 and falls at T+2S+2. The gate covers the switch by S cycles on each side.

## Structure
- cvmcu_io_pkg holds:
  - the state enum type cvmcu_io_pad_cfg_state_t;
  - the localparam defaults for N_PADS, SEL_W and CFG_W;
  - the packing helper constants.
- One sub-module, cvmcu_io_settle_timer:
  - loadable down-counter;
  - parameter WIDTH = $clog2(SETTLE_CYCLES+1);
  - inputs load and value;
  - output zero.
- A checker module bound to the controller asserts:
  - at most one pad_oe_gate_o bit is high;
  - pad_sel_o/pad_cfg_o change only in the cycle after SWITCH;
  - done_o and req_ready_o are never high together.

## Test plan
- Full update (S=4): after reset, request pad 5, sel 2'd3, cfg 6'h15. Required: gate[5] high T+1..T+9; sel[5]=3 and cfg[5]=0x15 from T+6; done_o at T+10; other pads unchanged.
- Invalid index: request pad 48. Required: done_o and err_o together at T+1; no output change; ready high at T+2.
- No-change request: repeat the previous request for pad 5. Required: done_o at T+1, err_o=0, gate[5] never asserted.
- Back-to-back: hold req_valid_i with pad 0 then pad 47. Required: second acceptance exactly at T+11; ready low throughout the first update; fields changing during busy are ignored.
- Reset mid-update: assert rst_i at T+6 of a pad-3 update to sel 1. Required at T+7: sel[3]=0, cfg[3]=CFG_RST, gate all 0, ready=1; no done_o.
- SETTLE_CYCLES=1: update pad 10. Required: gate high T+1..T+3, new sel visible from T+3, done_o at T+4.

Source files
------------

// File: rtl/cvmcu_io_pkg.sv
// Shared types and defaults for the IO pad reconfiguration controller.
// No logic; no latency; no backpressure.
package cvmcu_io_pkg;

    localparam int N_PADS_DEF = 48;
    localparam int SEL_W_DEF  = 2;
    localparam int CFG_W_DEF  = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GATE,
        ST_SWITCH,
        ST_HOLD,
        ST_DONE
    } cvmcu_io_pad_cfg_state_t;

    // LSB of pad p's field inside a flat per-pad bus.
    function automatic int pad_lsb(input int pad, input int width);
        return pad * width;
    endfunction

endpackage

// File: rtl/cvmcu_io_pad_cfg_chk.sv
// Protocol invariants for the pad reconfiguration controller, attached by bind.
// Observes only; no latency.
// No backpressure; never drives the design.
module cvmcu_io_pad_cfg_chk
    import cvmcu_io_pkg::*;
#(
    parameter int N_PADS = N_PADS_DEF,
    parameter int SEL_W  = SEL_W_DEF,
    parameter int CFG_W  = CFG_W_DEF
) (
    input logic                    clk_i,
    input logic                    rst_i,
    input cvmcu_io_pad_cfg_state_t state,
    input logic [N_PADS*SEL_W-1:0] pad_sel_o,
    input logic [N_PADS*CFG_W-1:0] pad_cfg_o,
    input logic [N_PADS-1:0]       pad_oe_gate_o,
    input logic                    done_o,
    input logic                    req_ready_o
);

    logic                    armed;
    cvmcu_io_pad_cfg_state_t prev_state;
    logic [N_PADS*SEL_W-1:0] prev_sel;
    logic [N_PADS*CFG_W-1:0] prev_cfg;

    // Disarmed for the cycle that shows reset values, since those may change pad state.
    always_ff @(posedge clk_i) begin
        armed      <= !rst_i;
        prev_state <= state;
        prev_sel   <= pad_sel_o;
        prev_cfg   <= pad_cfg_o;
        if (armed) begin
            assert ($countones(pad_oe_gate_o) <= 1);
            assert (!(done_o && req_ready_o));
            if ((pad_sel_o != prev_sel) || (pad_cfg_o != prev_cfg)) begin
                assert (prev_state == ST_SWITCH);
            end
        end
    end

endmodule

bind cvmcu_io_pad_cfg_ctrl cvmcu_io_pad_cfg_chk #(
    .N_PADS (N_PADS),
    .SEL_W  (SEL_W),
    .CFG_W  (CFG_W)
) u_chk (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .state         (state),
    .pad_sel_o     (pad_sel_o),
    .pad_cfg_o     (pad_cfg_o),
    .pad_oe_gate_o (pad_oe_gate_o),
    .done_o        (done_o),
    .req_ready_o   (req_ready_o)
);

// File: rtl/cvmcu_io_settle_timer.sv
// Loadable down-counter that flags when it has reached zero.
// Load takes effect on the next edge; zero is a direct decode of the count.
// No backpressure; load always wins over counting.
module cvmcu_io_settle_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/cvmcu_io_pad_cfg_ctrl.sv
// Glitch-safe pad mux/config update sequencer: gate OE, settle, switch, settle, release.
// Update latency 2*SETTLE_CYCLES+2 from acceptance; reject/no-change answer next cycle.
// One request at a time: req_ready_o is high only while idle.
module cvmcu_io_pad_cfg_ctrl
    import cvmcu_io_pkg::*;
#(
    parameter int               N_PADS        = N_PADS_DEF,
    parameter int               SEL_W         = SEL_W_DEF,
    parameter int               CFG_W         = CFG_W_DEF,
    parameter logic [CFG_W-1:0] CFG_RST       = '0,
    parameter int               SETTLE_CYCLES = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [$clog2(N_PADS)-1:0]  req_pad_i,
    input  logic [SEL_W-1:0]           req_sel_i,
    input  logic [CFG_W-1:0]           req_cfg_i,
    output logic [N_PADS*SEL_W-1:0]    pad_sel_o,
    output logic [N_PADS*CFG_W-1:0]    pad_cfg_o,
    output logic [N_PADS-1:0]          pad_oe_gate_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o
);

    localparam int PAD_W = $clog2(N_PADS);
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    cvmcu_io_pad_cfg_state_t state;

    logic [SEL_W-1:0] sel_q [N_PADS];
    logic [CFG_W-1:0] cfg_q [N_PADS];

    logic [PAD_W-1:0] pad_q;
    logic [SEL_W-1:0] new_sel_q;
    logic [CFG_W-1:0] new_cfg_q;

    logic             pad_ok;
    logic [PAD_W-1:0] pad_idx;
    logic             no_change;
    logic             tmr_load;
    logic             tmr_zero;

    // Out-of-range indices are steered to pad 0 only so the lookup stays defined.
    always_comb begin
        pad_ok    = (int'(req_pad_i) < N_PADS);
        pad_idx   = pad_ok ? req_pad_i : '0;
        no_change = (sel_q[pad_idx] == req_sel_i) && (cfg_q[pad_idx] == req_cfg_i);
        tmr_load  = ((state == ST_IDLE) && req_valid_i) || (state == ST_SWITCH);
    end

    cvmcu_io_settle_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .load  (tmr_load),
        .value (SETTLE_LOAD),
        .zero  (tmr_zero)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= ST_IDLE;
            req_ready_o   <= 1'b1;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
            pad_oe_gate_o <= '0;
            pad_q         <= '0;
            new_sel_q     <= '0;
            new_cfg_q     <= '0;
            for (int i = 0; i < N_PADS; i++) begin
                sel_q[i] <= '0;
                cfg_q[i] <= CFG_RST;
            end
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        pad_q       <= pad_idx;
                        new_sel_q   <= req_sel_i;
                        new_cfg_q   <= req_cfg_i;
                        req_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        if (!pad_ok) begin
                            state  <= ST_DONE;
                            done_o <= 1'b1;
                            err_o  <= 1'b1;
                        end else if (no_change) begin
                            state  <= ST_DONE;
                            done_o <= 1'b1;
                        end else begin
                            state                    <= ST_GATE;
                            pad_oe_gate_o[pad_idx]   <= 1'b1;
                        end
                    end
                end
                ST_GATE: begin
                    if (tmr_zero) begin
                        state <= ST_SWITCH;
                    end
                end
                ST_SWITCH: begin
                    sel_q[pad_q] <= new_sel_q;
                    cfg_q[pad_q] <= new_cfg_q;
                    state        <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (tmr_zero) begin
                        state         <= ST_DONE;
                        pad_oe_gate_o <= '0;
                        done_o        <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state       <= ST_IDLE;
                    req_ready_o <= 1'b1;
                    busy_o      <= 1'b0;
                end
                default: begin
                    state       <= ST_IDLE;
                    req_ready_o <= 1'b1;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < N_PADS; g++) begin : g_pack
        assign pad_sel_o[pad_lsb(g, SEL_W) +: SEL_W] = sel_q[g];
        assign pad_cfg_o[pad_lsb(g, CFG_W) +: CFG_W] = cfg_q[g];
    end

endmodule

// File: tb/tb_cvmcu_io_pad_cfg_ctrl.sv
// Bench for the pad reconfiguration controller: timeline model for S=4, directed S=1 checks.
module tb_cvmcu_io_pad_cfg_ctrl;

    localparam int N  = 48;
    localparam int SW = 2;
    localparam int CW = 6;
    localparam int PW = 6;
    localparam int S  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst = 1'b1, vld = 1'b0;
    logic [PW-1:0]   pad = '0;
    logic [SW-1:0]   sel = '0;
    logic [CW-1:0]   cfg = '0;
    logic            rdy, busy, done, err;
    logic [N*SW-1:0] psel;
    logic [N*CW-1:0] pcfg;
    logic [N-1:0]    gate;

    logic            rst1 = 1'b1, vld1 = 1'b0;
    logic [PW-1:0]   pad1 = '0;
    logic [SW-1:0]   sel1 = '0;
    logic [CW-1:0]   cfg1 = '0;
    logic            rdy1, busy1, done1, err1;
    logic [N*SW-1:0] psel1;
    logic [N*CW-1:0] pcfg1;
    logic [N-1:0]    gate1;

    cvmcu_io_pad_cfg_ctrl #(.N_PADS(N), .SEL_W(SW), .CFG_W(CW), .CFG_RST(6'b000000), .SETTLE_CYCLES(S)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(vld), .req_ready_o(rdy),
        .req_pad_i(pad), .req_sel_i(sel), .req_cfg_i(cfg),
        .pad_sel_o(psel), .pad_cfg_o(pcfg), .pad_oe_gate_o(gate),
        .busy_o(busy), .done_o(done), .err_o(err));

    cvmcu_io_pad_cfg_ctrl #(.N_PADS(N), .SEL_W(SW), .CFG_W(CW), .CFG_RST(6'b000000), .SETTLE_CYCLES(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst1), .req_valid_i(vld1), .req_ready_o(rdy1),
        .req_pad_i(pad1), .req_sel_i(sel1), .req_cfg_i(cfg1),
        .pad_sel_o(psel1), .pad_cfg_o(pcfg1), .pad_oe_gate_o(gate1),
        .busy_o(busy1), .done_o(done1), .err_o(err1));

    int total = 0;
    int bad   = 0;
    int c     = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [N*CW-1:0] act, input logic [N*CW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, c);
        end
    endtask

    // Timeline model: each accepted request is described by its acceptance cycle T.
    logic [SW-1:0] m_sel [N];
    logic [CW-1:0] m_cfg [N];
    logic [N-1:0]  e_gate = '0;
    bit            e_ready = 1'b1, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;
    int            kind = 0, t_acc = 0, a_pad = 0, rel = 0;
    logic [SW-1:0] a_sel;
    logic [CW-1:0] a_cfg;
    bit            a_err;

    always @(posedge clk) begin
        c = c + 1;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_sel[i] = '0;
                m_cfg[i] = '0;
            end
            e_gate = '0; e_ready = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
            kind = 0;
        end else begin
            if (e_ready && vld) begin
                t_acc = c - 1;
                a_pad = int'(pad);
                a_sel = sel;
                a_cfg = cfg;
                if (a_pad >= N) begin
                    kind = 2; a_err = 1'b1;
                end else if (m_sel[a_pad] == sel && m_cfg[a_pad] == cfg) begin
                    kind = 2; a_err = 1'b0;
                end else begin
                    kind = 1;
                end
            end
            rel = c - t_acc;
            e_gate = '0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
            if (kind == 1) begin
                if (rel <= 2*S + 2) begin
                    e_busy = 1'b1;
                    if (rel <= 2*S + 1) e_gate[a_pad] = 1'b1;
                    if (rel == S + 2) begin
                        m_sel[a_pad] = a_sel;
                        m_cfg[a_pad] = a_cfg;
                    end
                    if (rel == 2*S + 2) e_done = 1'b1;
                end else begin
                    kind = 0;
                end
            end else if (kind == 2) begin
                if (rel == 1) begin
                    e_busy = 1'b1; e_done = 1'b1; e_err = a_err;
                end else begin
                    kind = 0;
                end
            end
            e_ready = !e_busy;
        end
    end

    logic [N*SW-1:0] x_sel;
    logic [N*CW-1:0] x_cfg;

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < N; i++) begin
                x_sel[i*SW +: SW] = m_sel[i];
                x_cfg[i*CW +: CW] = m_cfg[i];
            end
            chk("m_pad_sel", psel, x_sel);
            chk("m_pad_cfg", pcfg, x_cfg);
            chk("m_gate", gate, e_gate);
            chk("m_ready", rdy, e_ready);
            chk("m_busy", busy, e_busy);
            chk("m_done", done, e_done);
            chk("m_err", err, e_err);
        end
    end

    task automatic wait_cyc(input int target);
        while (c < target) @(negedge clk);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (rdy !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("ready_timeout", 0, 1);
    endtask

    task automatic issue(input int p, input int s, input int f, output int t);
        wait_ready();
        vld = 1'b1;
        pad = PW'(p);
        sel = SW'(s);
        cfg = CW'(f);
        t = c;
        @(negedge clk);
        vld = 1'b0;
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk);
        rst  = 1'b0;
        rst1 = 1'b0;
        chk_on = 1'b1;

        chk("rst_ready", rdy, 1);
        chk("rst_busy", busy, 0);
        chk("rst_sel", psel, 0);
        chk("rst_cfg", pcfg, 0);
        chk("rst_gate", gate, 0);
        chk("rst_done", done, 0);

        // Full update of pad 5.
        issue(5, 3, 'h15, t);
        wait_cyc(t + 1);  chk("upd_gate_rise", gate[5], 1);
        wait_cyc(t + 5);  chk("upd_sel_old", psel[10 +: 2], 0);
        wait_cyc(t + 6);  chk("upd_sel_new", psel[10 +: 2], 3);
                          chk("upd_cfg_new", pcfg[30 +: 6], 'h15);
        wait_cyc(t + 9);  chk("upd_gate_last", gate[5], 1);
                          chk("upd_done_early", done, 0);
        wait_cyc(t + 10); chk("upd_done", done, 1);
                          chk("upd_gate_fall", gate, 0);
        wait_cyc(t + 11); chk("upd_ready_back", rdy, 1);

        // Out-of-range pad.
        issue(48, 1, 1, t);
        wait_cyc(t + 1);  chk("bad_done", done, 1);
                          chk("bad_err", err, 1);
        wait_cyc(t + 2);  chk("bad_ready", rdy, 1);

        // Repeat of the pad 5 update changes nothing.
        issue(5, 3, 'h15, t);
        wait_cyc(t + 1);  chk("same_done", done, 1);
                          chk("same_err", err, 0);
                          chk("same_gate", gate, 0);

        // Back-to-back with fields changing while busy.
        wait_ready();
        vld = 1'b1; pad = 6'd0; sel = 2'd1; cfg = 6'h2A;
        t = c;
        @(negedge clk);
        pad = 6'd47; sel = 2'd2; cfg = 6'h3F;
        wait_cyc(t + 5);  chk("b2b_ready_low", rdy, 0);
        wait_cyc(t + 10); chk("b2b_sel0", psel[0 +: 2], 1);
                          chk("b2b_cfg0", pcfg[0 +: 6], 'h2A);
        wait_cyc(t + 11); chk("b2b_ready_t11", rdy, 1);
        @(negedge clk);
        vld = 1'b0;
        chk("b2b_gate47", gate[47], 1);
        wait_cyc(t + 21); chk("b2b_done2", done, 1);
                          chk("b2b_sel47", psel[94 +: 2], 2);

        // Reset in the middle of a pad 3 update.
        issue(3, 1, 0, t);
        wait_cyc(t + 6);  chk("mid_sel_applied", psel[6 +: 2], 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_sel_rst", psel[6 +: 2], 0);
        chk("mid_cfg_rst", pcfg[18 +: 6], 0);
        chk("mid_gate_rst", gate, 0);
        chk("mid_ready_rst", rdy, 1);
        for (int k = 0; k < 12; k++) begin
            chk("mid_no_done", done, 0);
            @(negedge clk);
        end

        // Single-cycle settle instance.
        vld1 = 1'b1; pad1 = 6'd10; sel1 = 2'd2; cfg1 = 6'h11;
        t = c;
        @(negedge clk);
        vld1 = 1'b0;
        chk("s1_gate_t1", gate1[10], 1);
        wait_cyc(t + 2);  chk("s1_sel_t2", psel1[20 +: 2], 0);
        wait_cyc(t + 3);  chk("s1_sel_t3", psel1[20 +: 2], 2);
                          chk("s1_cfg_t3", pcfg1[60 +: 6], 'h11);
                          chk("s1_gate_t3", gate1[10], 1);
                          chk("s1_done_t3", done1, 0);
        wait_cyc(t + 4);  chk("s1_done_t4", done1, 1);
                          chk("s1_gate_t4", gate1, 0);
        wait_cyc(t + 5);  chk("s1_ready_t5", rdy1, 1);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            int p;
            p = $urandom_range(0, 50);
            vld = ($urandom_range(0, 9) < 6);
            pad = PW'(p);
            if (p < N && $urandom_range(0, 3) == 0) begin
                sel = m_sel[p];
                cfg = m_cfg[p];
            end else begin
                sel = SW'($urandom);
                cfg = CW'($urandom);
            end
            rst = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        vld = 1'b0;
        repeat (25) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
